counter_btn_debounce: RTL and testbench

//   Input-conditioning stage upstream of tt_um_simple_counter. Takes raw push-button

---
 rtl/counter_btn_debounce.sv | 152 +++++++++++++++
 tb/tb_counter_btn_debounce.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/counter_btn_debounce.sv
// Push-button conditioning: per-channel 2-flop sync, debounce, press/release
// pulses and optional auto-repeat while a button is held.
module counter_btn_debounce #(
    parameter int N_BTN           = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_DELAY    = 0,
    parameter int REPEAT_PERIOD   = 8,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        HOLD_WAIT = 2'd1,
        REPEATING = 2'd2
    } rep_state_t;

    localparam bit REPEAT_EN = (REPEAT_DELAY > 0);
    localparam int DLY_LAST_I = REPEAT_EN ? REPEAT_DELAY - 1 : 0;
    localparam int PER_LAST_I = (REPEAT_PERIOD > 0) ? REPEAT_PERIOD - 1 : 0;

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(DLY_LAST_I);
    localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(PER_LAST_I);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    genvar i;
    for (i = 0; i < N_BTN; i++) begin : g_ch

        logic             sync1_q;
        logic             sync2_q;
        logic [CNT_W-1:0] deb_q;
        logic [CNT_W-1:0] deb_d;
        logic             lvl_q;
        logic             lvl_d;
        logic             press_q;
        logic             press_d;
        logic             rel_q;
        logic             rel_d;
        logic [CNT_W-1:0] rep_q;
        logic [CNT_W-1:0] rep_d;
        rep_state_t       st_q;
        rep_state_t       st_d;
        logic             rise;
        logic             fall;

        // Synchroniser is free-running so ena never delays metastability settling
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync1_q <= 1'b0;
                sync2_q <= 1'b0;
            end else begin
                sync1_q <= btn_raw[i];
                sync2_q <= sync1_q;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                deb_q   <= '0;
                lvl_q   <= 1'b0;
                press_q <= 1'b0;
                rel_q   <= 1'b0;
                rep_q   <= '0;
                st_q    <= IDLE;
            end else begin
                deb_q   <= deb_d;
                lvl_q   <= lvl_d;
                press_q <= press_d;
                rel_q   <= rel_d;
                rep_q   <= rep_d;
                st_q    <= st_d;
            end
        end

        always_comb begin
            deb_d   = deb_q;
            lvl_d   = lvl_q;
            rep_d   = rep_q;
            st_d    = st_q;
            press_d = 1'b0;
            rel_d   = 1'b0;
            rise    = 1'b0;
            fall    = 1'b0;

            if (ena) begin
                if (sync2_q == lvl_q) begin
                    deb_d = '0;
                end else if (deb_q == DEB_LAST) begin
                    deb_d = '0;
                    lvl_d = sync2_q;
                    rise  = sync2_q;
                    fall  = ~sync2_q;
                end else begin
                    deb_d = deb_q + CNT_ONE;
                end

                press_d = rise;
                rel_d   = fall;

                // A release always wins over a repeat landing on the same edge
                if (fall) begin
                    st_d  = IDLE;
                    rep_d = '0;
                end else if (REPEAT_EN) begin
                    unique case (st_q)
                        IDLE: begin
                            if (rise) begin
                                st_d  = HOLD_WAIT;
                                rep_d = '0;
                            end
                        end
                        HOLD_WAIT: begin
                            if (rep_q == DLY_LAST) begin
                                press_d = 1'b1;
                                rep_d   = '0;
                                st_d    = REPEATING;
                            end else begin
                                rep_d = rep_q + CNT_ONE;
                            end
                        end
                        REPEATING: begin
                            if (rep_q == PER_LAST) begin
                                press_d = 1'b1;
                                rep_d   = '0;
                            end else begin
                                rep_d = rep_q + CNT_ONE;
                            end
                        end
                        default: begin
                            st_d  = IDLE;
                            rep_d = '0;
                        end
                    endcase
                end
            end
        end

        assign btn_level[i]   = lvl_q;
        assign btn_press[i]   = press_q;
        assign btn_release[i] = rel_q;

    end

endmodule

// File: tb/tb_counter_btn_debounce.sv
// Scoreboard bench for counter_btn_debounce: expected pulse events are
// queued when stimulus is driven and retired on the matching clock edge.
module tb_counter_btn_debounce;

    localparam int DEB = 4;
    localparam int DLY = 6;
    localparam int PER = 3;
    localparam int LAT = DEB + 2;

    localparam int K_RISE = 0;
    localparam int K_REP  = 1;
    localparam int K_FALL = 2;

    typedef struct {
        int cyc;
        int ch;
        int kind;
    } ev_t;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [1:0] btn_raw;
    logic [1:0] btn_level;
    logic [1:0] btn_press;
    logic [1:0] btn_release;

    int   cyc;
    int   n_chk;
    int   n_err;
    bit   mon_en;
    logic [1:0] exp_l;
    ev_t  q[$];

    counter_btn_debounce #(
        .N_BTN(2),
        .DEBOUNCE_CYCLES(DEB),
        .REPEAT_DELAY(DLY),
        .REPEAT_PERIOD(PER),
        .CNT_W(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .ena(ena),
        .btn_raw(btn_raw),
        .btn_level(btn_level),
        .btn_press(btn_press),
        .btn_release(btn_release)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    // Press at rise r, release accepted at f; repeats are those strictly before f
    task automatic sched(input int ch, input int r, input int f);
        ev_t e;
        e.ch   = ch;
        e.cyc  = r;
        e.kind = K_RISE;
        q.push_back(e);
        for (int t = r + DLY; t < f; t += PER) begin
            e.cyc  = t;
            e.kind = K_REP;
            q.push_back(e);
        end
        e.cyc  = f;
        e.kind = K_FALL;
        q.push_back(e);
    endtask

    task automatic push_ev(input int ch, input int c, input int kind);
        ev_t e;
        e.ch   = ch;
        e.cyc  = c;
        e.kind = kind;
        q.push_back(e);
    endtask

    task automatic to_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    always @(posedge clk) begin
        logic [1:0] exp_p;
        logic [1:0] exp_r;
        #1;
        if (mon_en) begin
            exp_p = 2'b00;
            exp_r = 2'b00;
            for (int j = q.size() - 1; j >= 0; j--) begin
                if (q[j].cyc <= cyc) begin
                    chk("ev_on_time", q[j].cyc, cyc);
                    case (q[j].kind)
                        K_RISE: begin
                            exp_p[q[j].ch] = 1'b1;
                            exp_l[q[j].ch] = 1'b1;
                        end
                        K_REP:  exp_p[q[j].ch] = 1'b1;
                        default: begin
                            exp_r[q[j].ch] = 1'b1;
                            exp_l[q[j].ch] = 1'b0;
                        end
                    endcase
                    q.delete(j);
                end
            end
            chk("press", btn_press, exp_p);
            chk("release", btn_release, exp_r);
            chk("level", btn_level, exp_l);
        end
    end

    initial begin
        int k;
        cyc     = 0;
        n_chk   = 0;
        n_err   = 0;
        mon_en  = 1'b0;
        exp_l   = 2'b00;
        rst_n   = 1'b0;
        ena     = 1'b1;
        btn_raw = 2'b11;

        // Reset held with buttons pressed
        repeat (8) @(negedge clk);
        chk("rst_level", btn_level, 2'b00);
        chk("rst_press", btn_press, 2'b00);
        chk("rst_release", btn_release, 2'b00);
        btn_raw = 2'b00;
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        repeat (4) @(negedge clk);

        // Clean press on channel 0
        k = cyc;
        btn_raw[0] = 1'b1;
        sched(0, k + LAT, k + 8 + LAT);
        to_cyc(k + 8);
        btn_raw[0] = 1'b0;
        to_cyc(k + 24);

        // Bounce then hold on channel 0
        k = cyc;
        btn_raw[0] = 1'b1;
        sched(0, k + 8 + LAT, k + 20 + LAT);
        to_cyc(k + 2);
        btn_raw[0] = 1'b0;
        to_cyc(k + 4);
        btn_raw[0] = 1'b1;
        to_cyc(k + 6);
        btn_raw[0] = 1'b0;
        to_cyc(k + 8);
        btn_raw[0] = 1'b1;
        to_cyc(k + 20);
        btn_raw[0] = 1'b0;
        to_cyc(k + 36);

        // Long hold on channel 1; last repeat slot collides with the release
        k = cyc;
        btn_raw[1] = 1'b1;
        sched(1, k + LAT, k + 30 + LAT);
        to_cyc(k + 30);
        btn_raw[1] = 1'b0;
        to_cyc(k + 46);

        // Both channels together, channel 0 released early
        k = cyc;
        btn_raw = 2'b11;
        sched(0, k + LAT, k + 10 + LAT);
        sched(1, k + LAT, k + 25 + LAT);
        to_cyc(k + 10);
        btn_raw[0] = 1'b0;
        to_cyc(k + 25);
        btn_raw[1] = 1'b0;
        to_cyc(k + 40);

        // ena dropped mid-debounce: timer holds, acceptance slips by 10
        k = cyc;
        btn_raw[0] = 1'b1;
        sched(0, k + LAT + 10, k + 30 + LAT);
        to_cyc(k + 3);
        ena = 1'b0;
        to_cyc(k + 13);
        ena = 1'b1;
        to_cyc(k + 30);
        btn_raw[0] = 1'b0;
        to_cyc(k + 46);

        // Asynchronous reset right after a repeat pulse
        k = cyc;
        btn_raw[1] = 1'b1;
        push_ev(1, k + LAT, K_RISE);
        push_ev(1, k + LAT + DLY, K_REP);
        to_cyc(k + LAT + DLY);
        mon_en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_level", btn_level, 2'b00);
        chk("arst_press", btn_press, 2'b00);
        chk("arst_release", btn_release, 2'b00);
        chk("arst_queue", q.size(), 0);
        q.delete();
        exp_l = 2'b00;
        repeat (3) @(negedge clk);
        chk("arst_hold_level", btn_level, 2'b00);

        // Recovery from all-zero state with the button still held
        k = cyc;
        rst_n  = 1'b1;
        mon_en = 1'b1;
        sched(1, k + LAT, k + 10 + LAT);
        to_cyc(k + 10);
        btn_raw[1] = 1'b0;
        to_cyc(k + 28);

        chk("drain", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
